// File: rtl/im_loader.sv
// Streams host bytes into instruction memory, one 32-bit word per write, holding the core until done.
// Latency: 4th byte of a word accepted at edge n -> IMwr_enable high in cycle n+1; ready low during WRITE/DONE.
module im_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  LDstart,
  input  logic [ADDR_WIDTH:0]   LDlength,
  input  logic                  LDbyte_valid,
  input  logic [7:0]            LDbyte,
  output logic                  LDbyte_ready,
  output logic                  IMwr_enable,
  output logic [31:0]           IMwr_address,
  output logic [31:0]           IMwr_data,
  output logic                  CPUhold,
  output logic                  LDbusy,
  output logic                  LDdone,
  output logic                  LDerror
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [1:0]            r_byte_idx;
  logic [31:0]           r_word;
  logic                  r_ready;
  logic                  r_wr_en;
  logic [31:0]           r_addr;
  logic [31:0]           r_data;
  logic                  r_hold;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_len_ok;
  logic                  w_fire;
  logic                  w_last_word;
  logic [31:0]           w_addr;

  assign w_len_ok    = (LDlength != '0) && (LDlength <= LEN_MAX);
  assign w_fire      = LDbyte_valid && r_ready;
  assign w_last_word = (({1'b0, r_word_idx} + (ADDR_WIDTH + 1)'(1)) == r_len);
  assign w_addr      = {{(30 - ADDR_WIDTH){1'b0}}, r_word_idx, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_ready    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_hold     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (LDstart) begin
            if (w_len_ok) begin
              r_len      <= LDlength;
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_hold     <= 1'b1;
              r_busy     <= 1'b1;
              r_ready    <= 1'b1;
              r_state    <= S_RECV;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (w_fire) begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= LDbyte;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_ready <= 1'b0;
              r_wr_en <= 1'b1;
              r_addr  <= w_addr;
              r_data  <= {LDbyte, r_word[23:0]};
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (w_last_word) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_word_idx <= r_word_idx + 1'b1;
            r_ready    <= 1'b1;
            r_state    <= S_RECV;
          end
        end
        S_DONE: begin
          r_hold  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign LDbyte_ready = r_ready;
  assign IMwr_enable  = r_wr_en;
  assign IMwr_address = r_addr;
  assign IMwr_data    = r_data;
  assign CPUhold      = r_hold;
  assign LDbusy       = r_busy;
  assign LDdone       = r_done;
  assign LDerror      = r_err;

endmodule
